register_file: RTL and testbench

- 32 x 64-bit LEGv8 general register file; sits directly upstream of the ALU and drives its A and B operands.
- Two combinational read ports and one synchronous write port, fed by the writeback mux.
- X31 (XZR) reads as zero. X28 (SP) resets to a configurable stack top.
- A third read-only debug port serves the testbench and the top-level display.

---
 rtl/processor_pkg.sv | 49 ++++
 rtl/register_file_read_port.sv | 52 +++++
 rtl/register_file.sv | 126 ++++++++++++
 tb/tb_register_file.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// ----------------------------------------------------------------------------
// processor_pkg
// Shared definitions for the LEGv8 datapath: operand/index widths, the named
// architectural register indices and the stack-pointer reset value. Imported
// by the register file, the ALU and the control decoder so that all three
// agree on widths and register numbering.
// Ports: none (package).
// ----------------------------------------------------------------------------
package processor_pkg;

  // Datapath geometry
  localparam int DATA_W     = 64;
  localparam int ADDR_W     = 5;
  localparam int NUM_REGS   = 32;
  localparam int WR_COUNT_W = 16;

  // Named architectural register indices
  localparam logic [ADDR_W-1:0] XZR = 5'd31;
  localparam logic [ADDR_W-1:0] SP  = 5'd28;
  localparam logic [ADDR_W-1:0] FP  = 5'd29;
  localparam logic [ADDR_W-1:0] LR  = 5'd30;

  // Default top of stack loaded into SP on reset
  localparam logic [DATA_W-1:0] SP_RESET_DEFAULT = 64'h0000_0000_0000_7FF8;

  // Saturation ceiling for the committed-write counter
  localparam logic [WR_COUNT_W-1:0] WR_COUNT_MAX = 16'hFFFF;

  // A write commits only when enabled and not aimed at the zero register
  function automatic logic is_commit(
    input logic              we,
    input logic [ADDR_W-1:0] idx,
    input logic [ADDR_W-1:0] zero_idx
  );
    return we && (idx != zero_idx);
  endfunction

  // Saturating increment: holds at the ceiling instead of wrapping
  function automatic logic [WR_COUNT_W-1:0] sat_inc(
    input logic [WR_COUNT_W-1:0] cnt
  );
    if (cnt == WR_COUNT_MAX) begin
      return cnt;
    end else begin
      return cnt + 16'd1;
    end
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// ----------------------------------------------------------------------------
// reg_read_port
// Combinational read mux for one register-file port. Index ZERO_REG always
// reads zero. When BYPASS is set, a read of the register being written in the
// current cycle returns the incoming write data instead of the stored value.
// Ports:
//   i_mem       - full register array contents
//   i_addr      - read index
//   i_rd        - write index of the current cycle
//   i_wr_data   - write data of the current cycle
//   i_reg_write - write enable of the current cycle
//   o_data      - selected read data
// ----------------------------------------------------------------------------
module reg_read_port #(
  parameter int                DATA_W   = processor_pkg::DATA_W,
  parameter int                ADDR_W   = processor_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ZERO_REG = processor_pkg::XZR,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic [DATA_W-1:0] i_mem [0:(2**ADDR_W)-1],
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_reg_write,
  output logic [DATA_W-1:0] o_data
);

  logic w_hit;

  // Forwarding hit: never on a write aimed at the zero register
  always_comb begin
    w_hit = 1'b0;
    if (BYPASS && i_reg_write && (i_addr == i_rd) && (i_rd != ZERO_REG)) begin
      w_hit = 1'b1;
    end else begin
      w_hit = 1'b0;
    end
  end

  // Read mux: zero register first, then forwarded data, then stored value
  always_comb begin
    o_data = '0;
    if (i_addr == ZERO_REG) begin
      o_data = '0;
    end else if (w_hit) begin
      o_data = i_wr_data;
    end else begin
      o_data = i_mem[i_addr];
    end
  end

endmodule

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
// 32 x 64-bit LEGv8 general register file. Two combinational read ports feed
// the ALU operands, one synchronous write port is fed by the writeback mux,
// and a raw (never forwarded) debug read port serves display and test.
// X31 reads as zero and ignores writes; SP resets to SP_RESET.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-high reset, reinitialises the array
//   rs1, rs2  - read indices for rd1 / rd2
//   rd        - write index
//   wr_data   - write data
//   reg_write - write enable
//   dbg_addr  - debug read index
//   rd1, rd2  - read data (optionally forwarded from the current write)
//   dbg_data  - debug read data, raw array contents
//   wr_count  - committed writes since reset, saturating at 16'hFFFF
// ----------------------------------------------------------------------------
module register_file #(
  parameter int                DATA_W   = processor_pkg::DATA_W,
  parameter int                ADDR_W   = processor_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] ZERO_REG = processor_pkg::XZR,
  parameter logic [ADDR_W-1:0] SP_REG   = processor_pkg::SP,
  parameter logic [DATA_W-1:0] SP_RESET = processor_pkg::SP_RESET_DEFAULT,
  parameter bit                BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  import processor_pkg::*;

  localparam int NUM_ENTRIES = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [0:NUM_ENTRIES-1];
  logic [15:0]       r_wr_count;
  logic              w_commit;

  // Write qualification shared by the array and the counter
  always_comb begin
    w_commit = 1'b0;
    if (is_commit(reg_write, rd, ZERO_REG)) begin
      w_commit = 1'b1;
    end else begin
      w_commit = 1'b0;
    end
  end

  // Register array: reset to zero except SP; reset beats a pending write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_mem[i] <= (i[ADDR_W-1:0] == SP_REG) ? SP_RESET : '0;
      end
    end else if (w_commit) begin
      r_mem[rd] <= wr_data;
    end
  end

  // Committed-write counter, saturating rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= 16'd0;
    end else if (w_commit) begin
      r_wr_count <= sat_inc(r_wr_count);
    end
  end

  assign wr_count = r_wr_count;

  // Operand port A
  reg_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port1 (
    .i_mem       (r_mem),
    .i_addr      (rs1),
    .i_rd        (rd),
    .i_wr_data   (wr_data),
    .i_reg_write (reg_write),
    .o_data      (rd1)
  );

  // Operand port B / store data
  reg_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_port2 (
    .i_mem       (r_mem),
    .i_addr      (rs2),
    .i_rd        (rd),
    .i_wr_data   (wr_data),
    .i_reg_write (reg_write),
    .o_data      (rd2)
  );

  // Debug port shows raw array contents, so forwarding is disabled
  reg_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (1'b0)
  ) u_port_dbg (
    .i_mem       (r_mem),
    .i_addr      (dbg_addr),
    .i_rd        (rd),
    .i_wr_data   (wr_data),
    .i_reg_write (1'b0),
    .o_data      (dbg_data)
  );

endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
// Directed bench for register_file. Two instances share all inputs: one with
// forwarding enabled, one with it disabled.
// ----------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, dbg_addr;
  logic [63:0] wr_data;
  logic        reg_write;

  logic [63:0] b_rd1, b_rd2, b_dbg;
  logic [15:0] b_cnt;
  logic [63:0] n_rd1, n_rd2, n_dbg;
  logic [15:0] n_cnt;

  int n_checks = 0;
  int n_errors = 0;

  register_file #(.BYPASS(1'b1)) dut_byp (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .wr_data(wr_data), .reg_write(reg_write), .dbg_addr(dbg_addr),
    .rd1(b_rd1), .rd2(b_rd2), .dbg_data(b_dbg), .wr_count(b_cnt)
  );

  register_file #(.BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
    .wr_data(wr_data), .reg_write(reg_write), .dbg_addr(dbg_addr),
    .rd1(n_rd1), .rd2(n_rd2), .dbg_data(n_dbg), .wr_count(n_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One committed cycle: drive at negedge, sample 1 time unit after posedge
  task automatic do_write(input logic [4:0] a, input logic [63:0] d);
    @(negedge clk);
    rd = a; wr_data = d; reg_write = 1'b1;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0;
    rs1 = 5'd28; rs2 = 5'd5; rd = 5'd0; wr_data = 64'd0; dbg_addr = 5'd28;
    #3;
    chk("reset_sp_rd1",  b_rd1, 64'h7FF8);
    chk("reset_x5_rd2",  b_rd2, 64'h0);
    chk("reset_sp_dbg",  b_dbg, 64'h7FF8);
    chk("reset_cnt",     {48'd0, b_cnt}, 64'd0);

    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Basic write and readback
    do_write(5'd3, 64'hDEAD_BEEF_0000_0001);
    rs1 = 5'd3; #1;
    chk("x3_rd1", b_rd1, 64'hDEAD_BEEF_0000_0001);
    chk("x3_cnt", {48'd0, b_cnt}, 64'd1);

    // Asynchronous mid-cycle reset restores reset values before next edge
    @(posedge clk); #2;
    reset = 1'b1; #1;
    chk("async_rst_x3",  b_rd1, 64'h0);
    chk("async_rst_cnt", {48'd0, b_cnt}, 64'd0);
    chk("async_rst_sp",  b_dbg, 64'h7FF8);
    @(negedge clk);
    reset = 1'b0;

    // Write to XZR is discarded and never forwarded
    do_write(5'd4, 64'h44);
    @(negedge clk);
    rd = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; reg_write = 1'b1;
    rs2 = 5'd31; dbg_addr = 5'd31; #1;
    chk("xzr_during_rd2", b_rd2, 64'h0);
    @(posedge clk); #1;
    reg_write = 1'b0; #1;
    chk("xzr_after_rd2", b_rd2, 64'h0);
    chk("xzr_after_dbg", b_dbg, 64'h0);
    chk("xzr_cnt",       {48'd0, b_cnt}, 64'd1);

    // Same-cycle forwarding, identical values on rs1 == rs2
    do_write(5'd7, 64'h5);
    @(negedge clk);
    rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7; dbg_addr = 5'd7;
    wr_data = 64'h1234; reg_write = 1'b1; #1;
    chk("byp_rd1",   b_rd1, 64'h1234);
    chk("byp_rd2",   b_rd2, 64'h1234);
    chk("byp_dbg",   b_dbg, 64'h5);
    chk("nobyp_rd1", n_rd1, 64'h5);
    chk("nobyp_rd2", n_rd2, 64'h5);
    rs2 = 5'd3; #1;
    chk("byp_other_reg", b_rd2, 64'h0);
    @(posedge clk); #1;
    reg_write = 1'b0; #1;
    chk("post_byp_rd1",   b_rd1, 64'h1234);
    chk("post_byp_dbg",   b_dbg, 64'h1234);
    chk("post_nobyp_rd2", n_rd1, 64'h1234);
    chk("post_byp_cnt",   {48'd0, b_cnt}, 64'd3);

    // Reset wins over a simultaneous write
    @(negedge clk);
    reset = 1'b1; rd = 5'd9; wr_data = 64'hAA; reg_write = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0; reg_write = 1'b0;
    dbg_addr = 5'd9;
    @(posedge clk); #1;
    chk("rst_wins_x9",  b_dbg, 64'h0);
    chk("rst_wins_cnt", {48'd0, b_cnt}, 64'd0);

    // First write right after release lands on the next edge
    do_write(5'd9, 64'hAA);
    chk("post_rel_x9", b_dbg, 64'hAA);

    // Counter saturation: 1 write so far, bring it to FFFE then FFFF
    for (int i = 0; i < 65533; i++) begin
      do_write(5'd1, 64'(i));
    end
    chk("cnt_fffe", {48'd0, b_cnt}, 64'hFFFE);
    do_write(5'd1, 64'd65533);
    chk("cnt_ffff", {48'd0, b_cnt}, 64'hFFFF);
    for (int i = 65534; i < 70000; i++) begin
      do_write(5'd1, 64'(i));
    end
    dbg_addr = 5'd1; #1;
    chk("cnt_sat",  {48'd0, b_cnt}, 64'hFFFF);
    chk("x1_last",  b_dbg, 64'd69999);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
